// File: rtl/core_boot_loader_if.sv
// Shared packet/store types and the bus bundle between the boot loader,
// its three ROMs, the data memory store port and the core's network port.
package core_boot_loader_pkg;

    typedef enum logic [2:0] {
        NET_NULL  = 3'd0,
        NET_INSTR = 3'd1,
        NET_REG   = 3'd2,
        NET_BAR   = 3'd3,
        NET_PC    = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [9:0]  net_id;
        net_op_e     net_op;
        logic [4:0]  reserved;
        logic [31:0] net_data;
        logic [9:0]  net_addr;
    } net_packet_s;

    typedef struct packed {
        logic        valid;
        logic        yumi;
        logic        wen;
        logic        byte_not_word;
        logic [31:0] write_data;
    } mem_in_s;

endpackage

interface core_boot_loader_if;
    import core_boot_loader_pkg::*;

    logic [9:0]  data_rom_addr_o;
    logic [31:0] data_rom_i;
    logic [9:0]  instr_rom_addr_o;
    logic [15:0] instr_rom_i;
    logic [5:0]  reg_rom_addr_o;
    logic [39:0] reg_rom_i;
    mem_in_s     mem_port_o;
    logic [31:0] mem_addr_o;
    logic        select_o;
    net_packet_s net_packet_o;

    // Loader side: drives ROM addresses, stores and packets.
    modport master (
        output data_rom_addr_o, instr_rom_addr_o, reg_rom_addr_o,
        output mem_port_o, mem_addr_o, select_o, net_packet_o,
        input  data_rom_i, instr_rom_i, reg_rom_i
    );

    // ROM / memory / core side.
    modport slave (
        input  data_rom_addr_o, instr_rom_addr_o, reg_rom_addr_o,
        input  mem_port_o, mem_addr_o, select_o, net_packet_o,
        output data_rom_i, instr_rom_i, reg_rom_i
    );

endinterface

// File: rtl/core_boot_loader.sv
// Boot sequencer: streams the data image into data memory, then the
// instruction and register images as packets, then BAR and PC packets,
// and finally hands data memory ownership to the core.
module core_boot_loader
    import core_boot_loader_pkg::*;
#(
    parameter int          DATA_COUNT_P  = 1024,
    parameter int          INSTR_COUNT_P = 1024,
    parameter int          REG_COUNT_P   = 64,
    parameter logic [9:0]  CORE_ID_P     = 10'd1,
    parameter logic [31:0] BAR_MASK_P    = 32'h2,
    parameter logic [9:0]  BAR_ADDR_P    = 10'd24,
    parameter logic [31:0] START_PC_P    = 32'h5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    core_boot_loader_if.master bus,
    output logic              busy_o,
    output logic              done_o
);

    localparam int MAX_DI_LP    = (DATA_COUNT_P > INSTR_COUNT_P) ? DATA_COUNT_P : INSTR_COUNT_P;
    localparam int MAX_COUNT_LP = (MAX_DI_LP > REG_COUNT_P) ? MAX_DI_LP : REG_COUNT_P;
    localparam int IDX_W_LP     = (MAX_COUNT_LP > 1) ? $clog2(MAX_COUNT_LP) : 1;

    localparam logic [IDX_W_LP-1:0] DATA_LAST_LP  = IDX_W_LP'(DATA_COUNT_P - 1);
    localparam logic [IDX_W_LP-1:0] INSTR_LAST_LP = IDX_W_LP'(INSTR_COUNT_P - 1);
    localparam logic [IDX_W_LP-1:0] REG_LAST_LP   = IDX_W_LP'(REG_COUNT_P - 1);

    if (DATA_COUNT_P < 1 || INSTR_COUNT_P < 1 || REG_COUNT_P < 1 ||
        DATA_COUNT_P > 1024 || INSTR_COUNT_P > 1024 || REG_COUNT_P > 64) begin : g_bad_count
        $error("core_boot_loader: COUNT parameters must be 1..ROM depth");
    end

    typedef enum logic [2:0] {
        ST_IDLE, ST_DATA, ST_GAP, ST_INSTR, ST_REG, ST_BAR, ST_PC, ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        TAG_DATA, TAG_INSTR, TAG_REG, TAG_BAR, TAG_PC
    } tag_e;

    state_e                state_q, state_d;
    logic [IDX_W_LP-1:0]   idx_q, idx_d;
    logic [IDX_W_LP-1:0]   k_q, k_d;
    logic                  gap_q, gap_d;
    logic                  select_q, select_d;
    logic                  issue_q, issue_d;
    tag_e                  tag_q, tag_d;
    logic                  start_prev_q, start_prev_d;

    logic [31:0] idx_ext;
    logic [31:0] k_ext;

    assign idx_ext = 32'(idx_q);
    assign k_ext   = 32'(k_q);

    // DONE is only reported once the PC packet has left the pipeline.
    assign done_o = (state_q == ST_DONE) && !issue_q;
    assign busy_o = (state_q != ST_IDLE) && !done_o;

    // State, index and issue-pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            k_q          <= '0;
            gap_q        <= 1'b0;
            select_q     <= 1'b0;
            issue_q      <= 1'b0;
            tag_q        <= TAG_DATA;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            k_q          <= k_d;
            gap_q        <= gap_d;
            select_q     <= select_d;
            issue_q      <= issue_d;
            tag_q        <= tag_d;
            start_prev_q <= start_prev_d;
        end
    end

    // Next state: walk the phases, issuing one ROM index per cycle.
    // A restart from DONE needs a fresh rising edge so a held start runs once.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        k_d          = idx_q;
        gap_d        = gap_q;
        select_d     = select_q;
        issue_d      = 1'b0;
        tag_d        = tag_q;
        start_prev_d = start_i;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_DATA;
                    idx_d    = '0;
                    select_d = 1'b0;
                end
            end
            ST_DATA: begin
                issue_d = 1'b1;
                tag_d   = TAG_DATA;
                if (idx_q == DATA_LAST_LP) begin
                    state_d = ST_GAP;
                    idx_d   = '0;
                    gap_d   = 1'b0;
                end else begin
                    idx_d = idx_q + IDX_W_LP'(1);
                end
            end
            ST_GAP: begin
                if (gap_q) begin
                    state_d  = ST_INSTR;
                    gap_d    = 1'b0;
                    select_d = 1'b1;
                end else begin
                    gap_d = 1'b1;
                end
            end
            ST_INSTR: begin
                issue_d = 1'b1;
                tag_d   = TAG_INSTR;
                if (idx_q == INSTR_LAST_LP) begin
                    state_d = ST_REG;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W_LP'(1);
                end
            end
            ST_REG: begin
                issue_d = 1'b1;
                tag_d   = TAG_REG;
                if (idx_q == REG_LAST_LP) begin
                    state_d = ST_BAR;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W_LP'(1);
                end
            end
            ST_BAR: begin
                issue_d = 1'b1;
                tag_d   = TAG_BAR;
                state_d = ST_PC;
            end
            ST_PC: begin
                issue_d = 1'b1;
                tag_d   = TAG_PC;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (done_o && start_i && !start_prev_q) begin
                    state_d  = ST_DATA;
                    idx_d    = '0;
                    select_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ROM addresses follow the index only during the matching issue phase.
    always_comb begin
        bus.data_rom_addr_o  = (state_q == ST_DATA)  ? idx_ext[9:0] : '0;
        bus.instr_rom_addr_o = (state_q == ST_INSTR) ? idx_ext[9:0] : '0;
        bus.reg_rom_addr_o   = (state_q == ST_REG)   ? idx_ext[5:0] : '0;
    end

    // Output stage: combine the registered issue tag with the ROM read data.
    always_comb begin
        bus.mem_port_o            = '0;
        bus.mem_addr_o            = '0;
        bus.select_o              = select_q;
        bus.net_packet_o          = '0;
        bus.net_packet_o.net_id   = CORE_ID_P;
        bus.net_packet_o.net_op   = NET_NULL;
        if (issue_q) begin
            unique case (tag_q)
                TAG_DATA: begin
                    bus.mem_port_o.valid         = 1'b1;
                    bus.mem_port_o.yumi          = 1'b1;
                    bus.mem_port_o.wen           = 1'b1;
                    bus.mem_port_o.byte_not_word = 1'b0;
                    bus.mem_port_o.write_data    = bus.data_rom_i;
                    bus.mem_addr_o               = {k_ext[29:0], 2'b00};
                end
                TAG_INSTR: begin
                    bus.net_packet_o.net_op   = NET_INSTR;
                    bus.net_packet_o.net_data = {16'b0, bus.instr_rom_i};
                    bus.net_packet_o.net_addr = k_ext[9:0];
                end
                TAG_REG: begin
                    bus.net_packet_o.net_op   = NET_REG;
                    bus.net_packet_o.net_data = bus.reg_rom_i[31:0];
                    bus.net_packet_o.net_addr = {4'b0, bus.reg_rom_i[37:32]};
                end
                TAG_BAR: begin
                    bus.net_packet_o.net_op   = NET_BAR;
                    bus.net_packet_o.net_data = BAR_MASK_P;
                    bus.net_packet_o.net_addr = BAR_ADDR_P;
                end
                TAG_PC: begin
                    bus.net_packet_o.net_op   = NET_PC;
                    bus.net_packet_o.net_data = START_PC_P;
                    bus.net_packet_o.net_addr = '0;
                end
                default: begin
                    bus.net_packet_o.net_op = NET_NULL;
                end
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.reg_rom_i[39:38], k_ext[31:30], idx_ext[31:10]};

endmodule

// File: tb/tb_core_boot_loader.sv
// Directed/randomized bench for core_boot_loader with small image sizes.
module tb_core_boot_loader;
    import core_boot_loader_pkg::*;

    localparam int          D   = 4;
    localparam int          I   = 3;
    localparam int          R   = 2;
    localparam logic [9:0]  CID = 10'd1;
    localparam logic [31:0] BMK = 32'h2;
    localparam logic [9:0]  BAD = 10'd24;
    localparam logic [31:0] SPC = 32'h5;
    localparam int          BOUND = D + I + R + 30;

    logic clk;
    logic reset;
    logic start_i;
    logic busy_o;
    logic done_o;

    core_boot_loader_if bus ();

    core_boot_loader #(
        .DATA_COUNT_P (D),
        .INSTR_COUNT_P(I),
        .REG_COUNT_P  (R),
        .CORE_ID_P    (CID),
        .BAR_MASK_P   (BMK),
        .BAR_ADDR_P   (BAD),
        .START_PC_P   (SPC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start_i(start_i),
        .bus    (bus),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] data_rom  [D];
    logic [15:0] instr_rom [I];
    logic [39:0] reg_rom   [R];

    // Synchronous ROM models: one cycle of read latency.
    always @(posedge clk) begin
        bus.data_rom_i  <= (int'(bus.data_rom_addr_o)  < D) ? data_rom[int'(bus.data_rom_addr_o)]   : 'x;
        bus.instr_rom_i <= (int'(bus.instr_rom_addr_o) < I) ? instr_rom[int'(bus.instr_rom_addr_o)] : 'x;
        bus.reg_rom_i   <= (int'(bus.reg_rom_addr_o)   < R) ? reg_rom[int'(bus.reg_rom_addr_o)]     : 'x;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    typedef struct {
        net_op_e     op;
        logic [31:0] data;
        logic [9:0]  addr;
    } pkt_t;

    st_t  q_st[$];
    pkt_t q_pk[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic net_packet_s null_pkt();
        net_packet_s p;
        p          = '0;
        p.net_id   = CID;
        p.net_op   = NET_NULL;
        return p;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_sel"},   64'(bus.select_o), 64'd0);
        chk({tag, "_busy"},  64'(busy_o), 64'd0);
        chk({tag, "_done"},  64'(done_o), 64'd0);
        chk({tag, "_mem"},   64'(bus.mem_port_o), 64'd0);
        chk({tag, "_net"},   64'(bus.net_packet_o), 64'(null_pkt()));
        chk({tag, "_roma"},  64'({bus.data_rom_addr_o, bus.instr_rom_addr_o, bus.reg_rom_addr_o}), 64'd0);
    endtask

    task automatic fill_roms();
        for (int k = 0; k < D; k++) data_rom[k] = $urandom;
        for (int k = 0; k < I; k++) instr_rom[k] = 16'($urandom);
        for (int k = 0; k < R; k++) reg_rom[k] = {2'b00, 6'($urandom), 32'($urandom)};
        instr_rom[1] = 16'hA9C3;
        reg_rom[1]   = 40'h25_DEADBEEF;
    endtask

    // Expected traffic of one boot, straight from the image contents.
    task automatic build_expect();
        pkt_t p;
        st_t  s;
        q_st.delete();
        q_pk.delete();
        for (int k = 0; k < D; k++) begin
            s.addr = 32'(k * 4);
            s.data = data_rom[k];
            q_st.push_back(s);
        end
        for (int k = 0; k < I; k++) begin
            p.op = NET_INSTR; p.data = {16'h0, instr_rom[k]}; p.addr = 10'(k);
            q_pk.push_back(p);
        end
        for (int k = 0; k < R; k++) begin
            p.op = NET_REG; p.data = reg_rom[k][31:0]; p.addr = {4'b0, reg_rom[k][37:32]};
            q_pk.push_back(p);
        end
        p.op = NET_BAR; p.data = BMK; p.addr = BAD; q_pk.push_back(p);
        p.op = NET_PC;  p.data = SPC; p.addr = 10'd0; q_pk.push_back(p);
    endtask

    // One full boot; start_i is raised in cycle N (called at #1 after an edge).
    task automatic run_boot(input bit hold, input bit fresh);
        bit          fin;
        int          first_store, sel_rise, last_pkt, done_c, n_st, n_pk, n_instr, n_reg;
        mem_in_s     mp;
        net_packet_s np;
        st_t         es;
        pkt_t        ep;
        if (fresh) fill_roms();
        build_expect();
        fin = 1'b0; first_store = -1; sel_rise = -1; last_pkt = -1; done_c = -1;
        n_st = 0; n_pk = 0; n_instr = 0; n_reg = 0;
        start_i = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_i = 1'b0;
        chk("busy_at_start", 64'(busy_o), 64'd1);
        chk("sel_low_at_start", 64'(bus.select_o), 64'd0);
        for (int c = 1; c <= BOUND && !fin; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            mp = bus.mem_port_o;
            np = bus.net_packet_o;
            if (mp.valid === 1'b1) begin
                n_st++;
                if (first_store < 0) first_store = c;
                chk("store_while_selected", 64'(bus.select_o), 64'd0);
                chk("store_flags", 64'({mp.yumi, mp.wen, mp.byte_not_word}), 64'b110);
                if (q_st.size() == 0) chk("extra_store", 64'd1, 64'd0);
                else begin
                    es = q_st.pop_front();
                    chk("store_addr", 64'(bus.mem_addr_o), 64'(es.addr));
                    chk("store_data", 64'(mp.write_data), 64'(es.data));
                end
            end else begin
                chk("idle_store_flags", 64'({mp.valid, mp.yumi, mp.wen}), 64'd0);
            end
            if (bus.select_o === 1'b1 && sel_rise < 0) sel_rise = c;
            if (np.net_op !== NET_NULL) begin
                n_pk++;
                last_pkt = c;
                chk("pkt_id", 64'(np.net_id), 64'(CID));
                chk("pkt_reserved", 64'(np.reserved), 64'd0);
                if (q_pk.size() == 0) chk("extra_pkt", 64'd1, 64'd0);
                else begin
                    ep = q_pk.pop_front();
                    chk("pkt_op",   64'(np.net_op),   64'(ep.op));
                    chk("pkt_data", 64'(np.net_data), 64'(ep.data));
                    chk("pkt_addr", 64'(np.net_addr), 64'(ep.addr));
                end
                if (np.net_op === NET_INSTR) begin
                    if (n_instr == 1) chk("instr_a9c3", 64'(np.net_data), 64'h0000_A9C3);
                    n_instr++;
                end
                if (np.net_op === NET_REG) begin
                    if (n_reg == 1) chk("reg_deadbeef", 64'({np.net_addr, np.net_data}), 64'h025_DEADBEEF);
                    n_reg++;
                end
            end
            if (done_o === 1'b1) begin
                done_c = c;
                fin    = 1'b1;
            end
        end
        chk("boot_timeout", 64'(fin), 64'd1);
        chk("first_store_cycle", 64'(first_store), 64'(2));
        chk("select_rise_cycle", 64'(sel_rise), 64'(D + 3));
        chk("last_pkt_cycle", 64'(last_pkt), 64'(D + I + R + 5));
        chk("done_cycle", 64'(done_c), 64'(D + I + R + 6));
        chk("store_count", 64'(n_st), 64'(D));
        chk("pkt_count", 64'(n_pk), 64'(I + R + 2));
        chk("done_busy", 64'(busy_o), 64'd0);
        chk("done_select", 64'(bus.select_o), 64'd1);
        chk("done_net_null", 64'(bus.net_packet_o), 64'(null_pkt()));
    endtask

    initial begin
        bit hit;
        reset   = 1'b1;
        start_i = 1'b0;
        fill_roms();
        #1;
        check_quiet("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset_held");
        reset = 1'b0;
        @(posedge clk); #1;
        check_quiet("idle");

        // Pulsed start from IDLE, then an identical replay from DONE.
        run_boot(1'b0, 1'b1);
        @(posedge clk); #1;
        run_boot(1'b0, 1'b0);

        // start_i held high: a single sequence, DONE holds afterwards.
        @(posedge clk); #1;
        run_boot(1'b1, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk("hold_no_store", 64'(bus.mem_port_o.valid), 64'd0);
            chk("hold_no_pkt", 64'(bus.net_packet_o), 64'(null_pkt()));
            chk("hold_done", 64'(done_o), 64'd1);
        end
        start_i = 1'b0;
        @(posedge clk); #1;

        // Reset while INSTR index 1 is being issued.
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < BOUND && !hit; c++) begin
            if (busy_o === 1'b1 && bus.select_o === 1'b1 && bus.instr_rom_addr_o === 10'd1) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("reach_instr1", 64'(hit), 64'd1);
        reset = 1'b1;
        #1;
        check_quiet("midreset_async");
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check_quiet("post_reset");
        end
        run_boot(1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/core_boot_loader.md
Name: core_boot_loader

Overview:
- Synthesizable boot sequencer that replaces the bench-driven init sequence.
- Streams three ROMs into the core's data memory and network port:
  - data-memory image as word stores;
  - instruction image as INSTR packets;
  - register image as REG packets;
  - then one BAR packet and one PC packet to start the core.
- Sits directly upstream of core_flattened (net_packet_flat_i) and data_mem (via select_o mux). Hands memory ownership to the core when finished.

Parameters:
- DATA_COUNT_P, 1024, number of 32-bit data words stored.
- INSTR_COUNT_P, 1024, number of instruction packets.
- REG_COUNT_P, 64, number of register packets (2**rs_imm_size_gp).
- CORE_ID_P, 10'd1, ID field of every packet.
- BAR_MASK_P, 32'h2, net_data of the BAR packet.
- BAR_ADDR_P, 10'd24, net_addr of the BAR packet.
- START_PC_P, 32'h5, net_data of the PC packet.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  begin boot sequence; sampled only in IDLE or DONE.
- data_rom_addr_o  out  10  data ROM word index.
- data_rom_i  in  32  data ROM read word; sync ROM, valid 1 cycle after address.
- instr_rom_addr_o  out  10  instruction ROM index.
- instr_rom_i  in  16  instruction word {opcode[15:11], rd[10:6], rs_imm[5:0]}; 1-cycle latency.
- reg_rom_addr_o  out  6  register ROM index.
- reg_rom_i  in  40  register entry: [37:32] register address, [31:0] value; 1-cycle latency.
- mem_port_o  out  $bits(mem_in_s)  store port to data_mem; fields valid, yumi, wen, byte_not_word, write_data.
- mem_addr_o  out  32  data memory byte address.
- select_o  out  1  0 = loader owns data memory; 1 = core owns it.
- net_packet_o  out  $bits(net_packet_s)  packet to core.
- busy_o  out  1  high from start until DONE.
- done_o  out  1  high while in DONE.

Behaviour:
- Reset values (reset is asynchronous; all outputs take these values immediately):
  - state = IDLE, index counter = 0;
  - select_o = 0, busy_o = 0, done_o = 0;
  - mem_port_o all zero;
  - net_packet_o = {ID CORE_ID_P, NULL, reserved 0, data 0, addr 0};
  - all ROM addresses = 0.
- States: IDLE → DATA → GAP → INSTR → REG → BAR → PC → DONE.
- IDLE: start_i=1 → DATA, index=0, busy_o=1.
- DATA / INSTR / REG issue phase:
  - each cycle drive the ROM address = index, then increment index.
  - On the cycle index==COUNT-1 is issued, go to the next state and reset index to 0.
- Issue pipeline:
  - A registered issue flag and a phase tag (DATA/INSTR/REG) follow each address by exactly 1 cycle.
  - The output for address k is valid in the cycle after k is issued, using the ROM data combinationally.
  - Phases are back-to-back with no bubble, except GAP.
- Data output (tag DATA):
  - mem valid=1, yumi=1, wen=1, byte_not_word=0;
  - write_data = data_rom_i; mem_addr_o = k*4.
  - Otherwise mem valid/yumi/wen = 0.
- GAP: exactly 2 cycles.
  - Cycle 1 emits the last data store (drain).
  - Cycle 2 has mem valid=0.
  - select_o rises to 1 on entry to INSTR and stays 1 through DONE.
  - No data store is ever emitted while select_o=1.
- INSTR output: net_op INSTR, net_data {16'b0, instr_rom_i}, net_addr k, reserved 0.
- REG output: net_op REG, net_data reg_rom_i[31:0], net_addr {4'b0, reg_rom_i[37:32]}.
- BAR (1 cycle): the last REG packet drains on this cycle; the BAR packet is emitted the following cycle, with net_data BAR_MASK_P and net_addr BAR_ADDR_P.
- PC (1 cycle): packet PC, net_data START_PC_P, net_addr 0; emitted the cycle after the BAR packet.
- DONE:
  - net_packet_o returns to NULL (data 0, addr 0); busy_o=0, done_o=1.
  - start_i=1 → restart at DATA: select_o drops to 0 the same edge, index=0.
- start_i while busy_o=1 is ignored.
- Reset asserted mid-sequence: immediate return to IDLE values. No partial packet or store is emitted after reset deasserts until a new start_i.
- Count arithmetic:
  - index is wide enough for max(COUNT)-1; no wrap occurs inside a phase.
  - A COUNT of 0 is illegal (compile-time assertion).
- Total packets per boot = INSTR_COUNT_P + REG_COUNT_P + 2. Total stores = DATA_COUNT_P.

Test Plan:
- Reset then start_i pulse at cycle N, small params (DATA 4, INSTR 3, REG 2):
  - stores at N+2..N+5 to addrs 0,4,8,C with ROM words;
  - select_o=1 from N+7; INSTR packets addr 0,1,2;
  - REG packets, then BAR(data 2, addr 24), then PC(data 5);
  - done_o=1 after PC.
- Instruction ROM word 16'hA9C3 at index 1 → packet net_data 32'h0000A9C3, net_addr 1, net_op INSTR.
- Register ROM entry 40'h25_DEADBEEF → net_addr 6'h25, net_data 32'hDEADBEEF.
- start_i held high for the whole run → exactly one sequence; store count = DATA_COUNT_P and packet count = INSTR+REG+2.
- Assert reset during INSTR index 1 → outputs NULL/zero immediately and select_o=0; a new start_i replays from data addr 0.
- start_i in DONE → select_o falls, the sequence repeats identically; monitor confirms no store ever occurs with select_o=1.
